// File: rtl/pipe_stage_reg.sv
// Pipeline boundary register: payload + control carried through a valid/ready stage with a 2-entry skid buffer.
// Define PIPE_STAGE_PERF_EN to add saturating stall_cnt / bubble_cnt performance counters.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
`ifdef PIPE_STAGE_PERF_EN
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt,
`endif
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl
);

    logic              m_v_q, m_v_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
    logic              s_v_q, s_v_d;
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;

    logic accept;
    logic deliver;
    logic main_free;

    // in_ready depends only on the skid flag, so out_ready never reaches upstream combinationally.
    assign in_ready  = ~s_v_q;
    assign out_valid = m_v_q;
    assign out_data  = m_data_q;
    assign out_ctrl  = m_v_q ? m_ctrl_q : '0;

    assign accept    = in_valid & in_ready;
    assign deliver   = m_v_q & out_ready;
    assign main_free = ~m_v_q | deliver;

    always_comb begin
        m_v_d    = m_v_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
        s_v_d    = s_v_q;
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
        if (flush) begin
            m_v_d = 1'b0;
            s_v_d = 1'b0;
        end else if (main_free) begin
            if (s_v_q) begin
                m_v_d    = 1'b1;
                m_data_d = s_data_q;
                m_ctrl_d = s_ctrl_q;
                s_v_d    = accept;
                if (accept) begin
                    s_data_d = in_data;
                    s_ctrl_d = in_ctrl;
                end
            end else begin
                m_v_d = accept;
                if (accept) begin
                    m_data_d = in_data;
                    m_ctrl_d = in_ctrl;
                end
            end
        end else if (accept) begin
            s_v_d    = 1'b1;
            s_data_d = in_data;
            s_ctrl_d = in_ctrl;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_v_q    <= 1'b0;
            m_data_q <= '0;
            m_ctrl_q <= '0;
            s_v_q    <= 1'b0;
            s_data_q <= '0;
            s_ctrl_q <= '0;
        end else begin
            m_v_q    <= m_v_d;
            m_data_q <= m_data_d;
            m_ctrl_q <= m_ctrl_d;
            s_v_q    <= s_v_d;
            s_data_q <= s_data_d;
            s_ctrl_q <= s_ctrl_d;
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

    // Counters saturate and deliberately ignore flush.
    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (m_v_q && !out_ready && !(&stall_cnt_q))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (!m_v_q && !(&bubble_cnt_q))
            bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt  = stall_cnt_q;
    assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and scoreboard-checked bench for pipe_stage_reg; perf counters are exercised when PIPE_STAGE_PERF_EN is defined.
module tb_pipe_stage_reg;

    localparam int DATA_W = 96;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  bubble_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_ctrl   (in_ctrl),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef PIPE_STAGE_PERF_EN
        .stall_cnt (stall_cnt),
        .bubble_cnt(bubble_cnt),
`endif
        .out_data  (out_data),
        .out_ctrl  (out_ctrl)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle; all driving and sampling happens 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [DATA_W-1:0] d, input logic [CTRL_W-1:0] c);
        in_valid = v;
        in_data  = d;
        in_ctrl  = c;
    endtask

    logic [DATA_W-1:0] q_data[$];
    logic [CTRL_W-1:0] q_ctrl[$];

    initial begin
        reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, '0, '0);
        #2;
        check("reset_out_valid", 128'(out_valid), 128'(0));
        check("reset_out_ctrl",  128'(out_ctrl),  128'(0));
        check("reset_out_data",  128'(out_data),  128'(0));
        check("reset_in_ready",  128'(in_ready),  128'(1));

        // Input offered while reset is held must not be captured.
        drive(1'b1, 96'hDEAD, 8'hFF);
        @(posedge clk); #1;
        check("reset_hold_valid", 128'(out_valid), 128'(0));
        drive(1'b0, '0, '0);
        #4 reset = 1'b1;
        tick();
        check("release_no_spurious", 128'(out_valid), 128'(0));
        check("release_in_ready",    128'(in_ready),  128'(1));

        // Unstalled stream: one-cycle latency, one per cycle.
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, DATA_W'(i), 8'h81);
            tick();
            check($sformatf("stream_valid_%0d", i), 128'(out_valid), 128'(1));
            check($sformatf("stream_data_%0d", i),  128'(out_data),  128'(i));
            check($sformatf("stream_ctrl_%0d", i),  128'(out_ctrl),  128'(8'h81));
        end
        drive(1'b0, '0, 8'h81);
        tick();
        check("stream_end_valid", 128'(out_valid), 128'(0));
        check("stream_end_ctrl",  128'(out_ctrl),  128'(0));

        // Back-pressure fills main then skid; C waits upstream.
        out_ready = 1'b0;
        drive(1'b1, 96'h10, 8'h01);
        tick();
        check("bp_a_data",  128'(out_data), 128'(96'h10));
        check("bp_a_ready", 128'(in_ready), 128'(1));
        drive(1'b1, 96'h20, 8'h02);
        tick();
        check("bp_b_ready", 128'(in_ready), 128'(0));
        check("bp_b_head",  128'(out_data), 128'(96'h10));
        drive(1'b1, 96'h30, 8'h03);
        tick();
        check("bp_c_hold_data",  128'(out_data), 128'(96'h10));
        check("bp_c_hold_ready", 128'(in_ready), 128'(0));
        out_ready = 1'b1;
        tick();
        check("bp_out_b_data",  128'(out_data), 128'(96'h20));
        check("bp_out_b_ctrl",  128'(out_ctrl), 128'(8'h02));
        check("bp_out_b_ready", 128'(in_ready), 128'(1));
        tick();
        check("bp_out_c_data", 128'(out_data), 128'(96'h30));
        check("bp_out_c_ctrl", 128'(out_ctrl), 128'(8'h03));
        drive(1'b0, '0, '0);
        tick();
        check("bp_drained", 128'(out_valid), 128'(0));

        // Flush with two entries held and 0x99 offered.
        out_ready = 1'b0;
        drive(1'b1, 96'h40, 8'h84);
        tick();
        drive(1'b1, 96'h50, 8'h85);
        tick();
        check("fl_full", 128'(in_ready), 128'(0));
        drive(1'b1, 96'h99, 8'hC9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check("fl_valid", 128'(out_valid), 128'(0));
        check("fl_ctrl",  128'(out_ctrl),  128'(0));
        check("fl_ready", 128'(in_ready),  128'(1));
        out_ready = 1'b1;
        tick();
        check("fl_no_99", 128'(out_valid), 128'(0));

        // Flush with one entry while an accept happens: accept is discarded.
        out_ready = 1'b0;
        drive(1'b1, 96'h60, 8'h86);
        tick();
        drive(1'b1, 96'h99, 8'hC9);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, '0, '0);
        check("fl2_valid", 128'(out_valid), 128'(0));
        check("fl2_ready", 128'(in_ready),  128'(1));
        out_ready = 1'b1;
        tick();
        check("fl2_no_99", 128'(out_valid), 128'(0));

        // Random traffic against an ideal 2-deep FIFO model.
        for (int c = 0; c < 1000; c++) begin
            logic acc, del;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 2) != 0);
            in_data   = {$urandom, $urandom, $urandom};
            in_ctrl   = 8'($urandom);
            acc = in_valid && (q_data.size() < 2);
            del = out_ready && (q_data.size() > 0);
            tick();
            if (del) begin
                void'(q_data.pop_front());
                void'(q_ctrl.pop_front());
            end
            if (acc) begin
                q_data.push_back(in_data);
                q_ctrl.push_back(in_ctrl);
            end
            check("rnd_valid", 128'(out_valid), 128'(q_data.size() > 0));
            check("rnd_ready", 128'(in_ready),  128'(q_data.size() < 2));
            if (q_data.size() > 0) begin
                check("rnd_data", 128'(out_data), 128'(q_data[0]));
                check("rnd_ctrl", 128'(out_ctrl), 128'(q_ctrl[0]));
            end else begin
                check("rnd_bubble_ctrl", 128'(out_ctrl), 128'(0));
            end
        end

        // Reset asserted mid-transfer clears entries immediately.
        drive(1'b1, 96'h77, 8'h87);
        out_ready = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        check("midreset_valid", 128'(out_valid), 128'(0));
        check("midreset_ready", 128'(in_ready),  128'(1));
        check("midreset_data",  128'(out_data),  128'(0));
        drive(1'b0, '0, '0);
        #1 reset = 1'b1;
        tick();
        check("midreset_after", 128'(out_valid), 128'(0));

`ifdef PIPE_STAGE_PERF_EN
        reset = 1'b0;
        #4 reset = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        check("perf_bubble_3", 128'(bubble_cnt), 128'(3));
        check("perf_stall_0",  128'(stall_cnt),  128'(0));
        out_ready = 1'b0;
        drive(1'b1, 96'hAB, 8'h01);
        tick();
        drive(1'b0, '0, '0);
        for (int k = 0; k < 20; k++) tick();
        check("perf_stall_sat", 128'(stall_cnt),  128'(15));
        check("perf_bubble_4",  128'(bubble_cnt), 128'(4));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
